// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer: FSM encoding, default pattern, frame length.
// PATTERN_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package pattern_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Same pattern the sequence detector bench searches for.
  localparam logic [4:0] DEF_PATTERN = 5'b01101;

  function automatic int frame_len(input int width);
`ifdef PATTERN_SERIALIZER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/pattern_serializer_shreg.sv
// Loadable left-shift register with a bit counter; msb_o is the serial bit and
// last_bit_o flags the final bit of the frame.
module pattern_shreg #(
  parameter int LEN = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic           shift_i,
  input  logic [LEN-1:0] load_val_i,
  output logic           msb_o,
  output logic           last_bit_o
);

  localparam int CNT_W = $clog2(LEN);

  logic [LEN-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_bit_o = (cnt_q == CNT_W'(LEN - 1));
  assign msb_o      = sh_q[LEN-1];

  // NOTE: every variable gets a default before the if-chain, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = load_val_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sh_d  = {sh_q[LEN-2:0], 1'b0};
      cnt_d = last_bit_o ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// Serial pattern transmitter: sends a WIDTH-bit pattern MSB first, reps times,
// with GAP idle cycles between repetitions. Optional macro: PATTERN_SERIALIZER_PARITY_EN.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int               WIDTH   = 5,
  parameter int               REP_W   = 4,
  parameter int               GAP     = 0,
  parameter logic [WIDTH-1:0] DEF_PAT = WIDTH'(DEF_PATTERN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [WIDTH-1:0] pat_in,
  input  logic [REP_W-1:0] reps,
  output logic             o,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int               FRAME    = frame_len(WIDTH);
  localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  function automatic logic [FRAME-1:0] build_frame(input logic [WIDTH-1:0] p);
`ifdef PATTERN_SERIALIZER_PARITY_EN
    return {p, ^p};
`else
    return p;
`endif
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             sr_load, sr_shift, sr_msb, sr_last;
  logic [FRAME-1:0] sr_load_val;
  logic [WIDTH-1:0] sel_pat;

  assign sel_pat = use_def ? DEF_PAT : pat_in;

  pattern_shreg #(
    .LEN (FRAME)
  ) u_shreg (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (sr_load),
    .shift_i    (sr_shift),
    .load_val_i (sr_load_val),
    .msb_o      (sr_msb),
    .last_bit_o (sr_last)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    rep_d       = rep_q;
    gap_d       = gap_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_load_val = build_frame(pat_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (reps != '0) begin
            pat_d       = sel_pat;
            rep_d       = reps;
            sr_load     = 1'b1;
            sr_load_val = build_frame(sel_pat);
            state_d     = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_SHIFT: begin
        sr_shift = 1'b1;
        if (sr_last) begin
          rep_d = rep_q - 1'b1;
          if (rep_q != REP_W'(1)) begin
            if (GAP > 0) begin
              gap_d   = '0;
              state_d = ST_GAP;
            end else begin
              // Back-to-back: reloading here wins over the shift, so no bubble.
              sr_load = 1'b1;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          sr_load = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
    end
  end

  // Moore outputs: decoded from registered state only.
  assign valid = (state_q == ST_SHIFT);
  assign o     = valid & sr_msb;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);

endmodule
